// File: rtl/tft_spi_pkg.sv
// Shared types for the TFT SPI transmitter: FSM encoding, FIFO entry format
// and the panel command bytes used by the drawing stages.
package tft_spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SETUP = 3'd2,
        ST_LOW   = 3'd3,
        ST_HIGH  = 3'd4
    } tx_state_t;

    typedef struct packed {
        logic       dc;
        logic [7:0] data;
    } tft_byte_t;

    localparam logic [7:0] CMD_CASET = 8'h2A;
    localparam logic [7:0] CMD_PASET = 8'h2B;
    localparam logic [7:0] CMD_RAMWR = 8'h2C;

endpackage

// File: rtl/tft_spi_tx_if.sv
// Byte write handshake between the drawing stages (master) and the SPI
// transmitter (slave), including status flags and the overflow clear.
interface tft_spi_tx_if;
    logic       tft_transmit;
    logic       tft_dc;
    logic [7:0] tft_data;
    logic       tft_busy;
    logic       tx_idle;
    logic       overflow;
    logic       overflow_clr;

    modport master (
        output tft_transmit, tft_dc, tft_data, overflow_clr,
        input  tft_busy, tx_idle, overflow
    );

    modport slave (
        input  tft_transmit, tft_dc, tft_data, overflow_clr,
        output tft_busy, tx_idle, overflow
    );
endinterface

// File: rtl/tft_byte_fifo.sv
// Synchronous FIFO of {dc,data} entries; DEPTH must be a power of two so the
// pointers wrap naturally. Push while full and pop while empty are ignored.
module tft_byte_fifo
    import tft_spi_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  tft_byte_t                wr_data,
    input  logic                     pop,
    output tft_byte_t                rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    tft_byte_t         mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              push_ok;
    logic              pop_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wr_data;
    end
endmodule

// File: rtl/tft_spi_tx.sv
// Byte-level SPI (mode 0, MSB first) transmitter to the TFT panel with input FIFO.
// Define TFT_SPI_CS_IDLE_EN to release chip select after CS_IDLE_CYCLES idle clocks.
//
// state | meaning
// IDLE  | waiting for a FIFO entry
// LOAD  | pop entry, present dc and bit 7, assert CS (1 clk)
// SETUP | CS-to-SCK setup after CS was released, SCK low
// LOW   | SCK low half-period, data may change
// HIGH  | SCK high half-period, panel samples
module tft_spi_tx
    import tft_spi_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int CLK_DIV        = 2,
    parameter int CS_IDLE_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    tft_spi_tx_if.slave wr,
    output logic        spi_sck,
    output logic        spi_mosi,
    output logic        spi_dc,
    output logic        spi_cs_n
);
    localparam int                CNT_W    = $clog2(FIFO_DEPTH) + 1;
    localparam int                DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);

    tx_state_t          state;
    tx_state_t          state_next;
    tft_byte_t          fifo_wr;
    tft_byte_t          fifo_rd;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_pop;
    logic [CNT_W-1:0]   fifo_count;
    logic [DIV_W-1:0]   div_cnt;
    logic               div_done;
    logic [7:0]         shreg;
    logic [2:0]         bit_idx;
    logic               overflow_q;
    logic               cs_release;

    assign fifo_wr = {wr.tft_dc, wr.tft_data};

    tft_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (wr.tft_transmit),
        .wr_data (fifo_wr),
        .pop     (fifo_pop),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // busy is the full compare on the registered count, so a push and pop
    // in the same full cycle still refuses the push
    assign wr.tft_busy = fifo_full;
    assign wr.overflow = overflow_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                  overflow_q <= 1'b0;
        else if (wr.tft_transmit && fifo_full)    overflow_q <= 1'b1;
        else if (wr.overflow_clr)                 overflow_q <= 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    assign div_done = (div_cnt == DIV_LAST);

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (!fifo_empty) state_next = ST_LOAD;
            ST_LOAD:  state_next = spi_cs_n ? ST_SETUP : ST_LOW;
            ST_SETUP: if (div_done) state_next = ST_LOW;
            ST_LOW:   if (div_done) state_next = ST_HIGH;
            ST_HIGH: begin
                if (div_done) begin
                    if (bit_idx != 3'd0) state_next = ST_LOW;
                    else if (fifo_empty) state_next = ST_IDLE;
                    else                 state_next = ST_LOAD;
                end
            end
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        fifo_pop   = (state == ST_LOAD);
        spi_sck    = (state == ST_HIGH);
        wr.tx_idle = (state == ST_IDLE) && (fifo_count == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                              div_cnt <= '0;
        else if (state_next != state)                         div_cnt <= '0;
        else if ((state inside {ST_SETUP, ST_LOW, ST_HIGH}) && !div_done)
                                                              div_cnt <= div_cnt + 1'b1;
    end

    // MOSI is the shifter MSB; it only moves on LOAD exit or HIGH exit, i.e. with SCK low
    assign spi_mosi = shreg[7];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg    <= '0;
            bit_idx  <= '0;
            spi_dc   <= 1'b0;
            spi_cs_n <= 1'b1;
        end else if (state == ST_LOAD) begin
            shreg    <= fifo_rd.data;
            spi_dc   <= fifo_rd.dc;
            spi_cs_n <= 1'b0;
            bit_idx  <= 3'd7;
        end else if (state == ST_HIGH && div_done && bit_idx != 3'd0) begin
            shreg    <= {shreg[6:0], 1'b0};
            bit_idx  <= bit_idx - 1'b1;
        end else if (cs_release) begin
            spi_cs_n <= 1'b1;
        end
    end

`ifdef TFT_SPI_CS_IDLE_EN
    localparam int IDLE_W = $clog2(CS_IDLE_CYCLES + 1);

    logic [IDLE_W-1:0] idle_cnt;
    logic              idle_quiet;

    assign idle_quiet = (state == ST_IDLE) && fifo_empty && !wr.tft_transmit;
    assign cs_release = idle_quiet && (idle_cnt == IDLE_W'(CS_IDLE_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                          idle_cnt <= '0;
        else if (!idle_quiet)                             idle_cnt <= '0;
        else if (idle_cnt != IDLE_W'(CS_IDLE_CYCLES))     idle_cnt <= idle_cnt + 1'b1;
    end
`else
    assign cs_release = 1'b0;
`endif

endmodule

// File: tb/tb_tft_spi_tx.sv
// Directed bench for tft_spi_tx: reset state, single byte timing, burst order,
// FIFO overflow, reset mid-byte and CS idle behaviour (with or without the macro).
module tb_tft_spi_tx;
    import tft_spi_pkg::*;

    typedef struct packed {
        logic       dc;
        logic [7:0] data;
        logic [8:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic spi_sck, spi_mosi, spi_dc, spi_cs_n;

    always #5 clk = ~clk;

    tft_spi_tx_if wr();

    tft_spi_tx #(.FIFO_DEPTH(4), .CLK_DIV(2), .CS_IDLE_CYCLES(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr       (wr),
        .spi_sck  (spi_sck),
        .spi_mosi (spi_mosi),
        .spi_dc   (spi_dc),
        .spi_cs_n (spi_cs_n)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int last_push_cyc = 0;

    always @(posedge clk) cyc++;

    // serial monitor, sampled on the falling clk edge
    logic       sck_q = 1'b0, mosi_q = 1'b0, dc_q = 1'b0;
    int         nb = 0;
    logic [7:0] cur = '0;
    logic [8:0] rx_q[$];
    logic       bit_q[$];
    int         rise_q[$];
    int         glitches = 0;

    always @(negedge clk) begin
        if (rst) begin
            nb = 0;
        end else begin
            if (spi_sck && !sck_q) begin
                rise_q.push_back(cyc);
                bit_q.push_back(spi_mosi);
                cur = {cur[6:0], spi_mosi};
                nb++;
                if (nb == 8) begin
                    rx_q.push_back({spi_dc, cur});
                    nb = 0;
                end
            end
            if (spi_sck && sck_q && (spi_mosi !== mosi_q || spi_dc !== dc_q)) glitches++;
        end
        sck_q  = spi_sck;
        mosi_q = spi_mosi;
        dc_q   = spi_dc;
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        rx_q.delete();
        bit_q.delete();
        rise_q.delete();
        glitches = 0;
    endtask

    // called at a falling edge; returns at the falling edge after the push edge
    task automatic push_byte(input logic dc, input logic [7:0] data);
        int k = 0;
        while (wr.tft_busy && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (k >= 200) check("push_busy_timeout", 1, 0);
        wr.tft_transmit = 1'b1;
        wr.tft_dc       = dc;
        wr.tft_data     = data;
        @(negedge clk);
        last_push_cyc   = cyc;
        wr.tft_transmit = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int limit);
        int k = 0;
        while (!wr.tx_idle && k < limit) begin
            @(negedge clk);
            k++;
        end
        check(name, int'(wr.tx_idle), 1);
    endtask

    vec_t       seq2 [5];
    logic [8:0] exp3 [5];
    logic       bsy3 [5];
    logic       ovf3 [5];
    logic       bits_2a [8];
    int         max_gap;
    int         k;
    int         t_idle;

    initial begin
        seq2[0] = '{1'b0, 8'h2A, 9'h02A};
        seq2[1] = '{1'b1, 8'h00, 9'h100};
        seq2[2] = '{1'b1, 8'h05, 9'h105};
        seq2[3] = '{1'b1, 8'h00, 9'h100};
        seq2[4] = '{1'b1, 8'h1A, 9'h11A};
        exp3    = '{9'h099, 9'h111, 9'h122, 9'h133, 9'h144};
        bsy3    = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        ovf3    = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        bits_2a = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

        wr.tft_transmit = 1'b0;
        wr.tft_dc       = 1'b0;
        wr.tft_data     = '0;
        wr.overflow_clr = 1'b0;

        // reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy",     int'(wr.tft_busy), 0);
        check("rst_tx_idle",  int'(wr.tx_idle),  1);
        check("rst_overflow", int'(wr.overflow), 0);
        check("rst_sck",      int'(spi_sck),     0);
        check("rst_mosi",     int'(spi_mosi),    0);
        check("rst_dc",       int'(spi_dc),      0);
        check("rst_cs_n",     int'(spi_cs_n),    1);
        rst = 1'b0;
        @(negedge clk);

        // single command byte 0x2A
        clear_mon();
        push_byte(1'b0, CMD_CASET);
        check("t1_idle_falls", int'(wr.tx_idle), 0);
        wait_idle("t1_idle_timeout", 200);
        t_idle = cyc - last_push_cyc;
        // 1 clk for IDLE to see the entry, then LOAD + SETUP(2) + 16 half-periods of 2
        check("t1_idle_latency", t_idle, 36);
        check("t1_rises", rise_q.size(), 8);
        for (int i = 0; i < 8; i++) check($sformatf("t1_bit%0d", i), int'(bit_q[i]), int'(bits_2a[i]));
        check("t1_rx", int'(rx_q[0]), 9'h02A);
        check("t1_first_rise", rise_q[0] - last_push_cyc, 6);
        check("t1_cs_low", int'(spi_cs_n), 0);

        // player-style burst, one strobe whenever not busy
        clear_mon();
        for (int i = 0; i < 5; i++) push_byte(seq2[i].dc, seq2[i].data);
        wait_idle("t2_idle_timeout", 400);
        check("t2_count", rx_q.size(), 5);
        for (int i = 0; i < 5; i++) check($sformatf("t2_byte%0d", i), int'(rx_q[i]), int'(seq2[i].exp));
        max_gap = 0;
        for (int i = 1; i < rise_q.size(); i++)
            if (rise_q[i] - rise_q[i-1] > max_gap) max_gap = rise_q[i] - rise_q[i-1];
        check("t2_max_rise_gap", max_gap, 5);
        check("t2_glitches", glitches, 0);

        // overflow: shifter busy with 0x99 while five pushes arrive back to back
        clear_mon();
        push_byte(1'b0, 8'h99);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            wr.tft_transmit = 1'b1;
            wr.tft_dc       = 1'b1;
            wr.tft_data     = 8'(8'h11 * (i + 1));
            @(negedge clk);
            check($sformatf("t3_busy%0d", i), int'(wr.tft_busy), int'(bsy3[i]));
            check($sformatf("t3_ovf%0d", i),  int'(wr.overflow), int'(ovf3[i]));
        end
        wr.overflow_clr = 1'b1;
        @(negedge clk);
        check("t3_clr_vs_event", int'(wr.overflow), 1);
        wr.tft_transmit = 1'b0;
        @(negedge clk);
        check("t3_clr", int'(wr.overflow), 0);
        wr.overflow_clr = 1'b0;
        wait_idle("t3_idle_timeout", 600);
        check("t3_count", rx_q.size(), 5);
        for (int i = 0; i < 5; i++) check($sformatf("t3_byte%0d", i), int'(rx_q[i]), int'(exp3[i]));

        // reset mid-byte after three SCK rises
        clear_mon();
        push_byte(1'b0, 8'hF0);
        push_byte(1'b1, 8'h0F);
        k = 0;
        while (rise_q.size() < 3 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("t4_three_rises", rise_q.size(), 3);
        #2 rst = 1'b1;
        #1;
        check("t4_cs_n",    int'(spi_cs_n),    1);
        check("t4_sck",     int'(spi_sck),     0);
        check("t4_busy",    int'(wr.tft_busy), 0);
        check("t4_tx_idle", int'(wr.tx_idle),  1);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        check("t4_no_more_rises", rise_q.size(), 3);
        check("t4_no_bytes", rx_q.size(), 0);
        check("t4_still_idle", int'(wr.tx_idle), 1);

        // chip select behaviour between separated bytes
        clear_mon();
        push_byte(1'b0, CMD_RAMWR);
        check("t5_first_setup", rise_q.size() > 0 ? rise_q[0] - last_push_cyc : 0, 0);
        wait_idle("t5_idle1_timeout", 200);
        check("t5_first_rise", rise_q[0] - last_push_cyc, 6);
`ifdef TFT_SPI_CS_IDLE_EN
        k = 0;
        while (spi_cs_n == 1'b0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("t5_cs_release_delay", k, 16);
        push_byte(1'b1, 8'h5A);
        wait_idle("t5_idle2_timeout", 200);
        check("t5_second_rise", rise_q[8] - last_push_cyc, 6);
`else
        repeat (40) @(negedge clk);
        check("t5_cs_held", int'(spi_cs_n), 0);
        push_byte(1'b1, 8'h5A);
        wait_idle("t5_idle2_timeout", 200);
        check("t5_second_rise", rise_q[8] - last_push_cyc, 4);
`endif
        check("t5_rx", int'(rx_q[1]), 9'h15A);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
